// File: rtl/charram_dram_ctrl.sv
// Character-RAM DRAM controller for a 4416 (16K x 4) DRAM.
// Video and CPU share fixed 8-clock slots. Even slots favour video and odd
// slots favour the CPU. A slot that nobody claims becomes a RAS-only refresh
// cycle, or stays idle when refresh is disabled. All DRAM strobes, address,
// write data and requester responses are registered.
module charram_dram_ctrl #(
    parameter logic REFRESH_EN = 1'b1
) (
    input  logic        i_MCLK,
    input  logic        i_RST,
    input  logic        i_VID_REQ,
    input  logic [13:0] i_VID_ADDR,
    output logic [3:0]  o_VID_DATA,
    output logic        o_VID_VALID,
    input  logic        i_CPU_REQ,
    input  logic        i_CPU_WE,
    input  logic [13:0] i_CPU_ADDR,
    input  logic [3:0]  i_CPU_DIN,
    output logic [3:0]  o_CPU_DOUT,
    output logic        o_CPU_ACK,
    output logic [7:0]  o_DRAM_ADDR,
    output logic [3:0]  o_DRAM_DIN,
    input  logic [3:0]  i_DRAM_DOUT,
    output logic        o_RAS_n,
    output logic        o_CAS_n,
    output logic        o_WR_n,
    output logic        o_RD_n
);

    typedef enum logic [1:0] {
        GNT_IDLE = 2'd0,
        GNT_VID  = 2'd1,
        GNT_CPU  = 2'd2,
        GNT_REF  = 2'd3
    } grant_t;

    // slot sequencer state
    logic [2:0]  phase_r;
    logic        parity_r;
    grant_t      grant_r;
    logic [13:0] addr_lat_r;
    logic        we_lat_r;
    logic [3:0]  din_lat_r;
    logic [7:0]  refcnt_r;

    // registered DRAM side and responses
    logic [7:0]  dram_addr_r;
    logic [3:0]  dram_din_r;
    logic        ras_n_r;
    logic        cas_n_r;
    logic        wr_n_r;
    logic        rd_n_r;
    logic [3:0]  vid_data_r;
    logic [3:0]  cpu_dout_r;
    logic        vid_valid_r;
    logic        cpu_ack_r;

    // values that the sequencer will hold after the coming edge
    grant_t      arb_s;
    logic [2:0]  phase_nx_s;
    grant_t      grant_nx_s;
    logic [13:0] addr_nx_s;
    logic        we_nx_s;
    logic [3:0]  din_nx_s;
    logic        is_write_s;
    logic [7:0]  row_s;
    logic [7:0]  col_s;

    // values for the DRAM output registers in the coming phase
    logic [7:0]  dram_addr_nx_s;
    logic [3:0]  dram_din_nx_s;
    logic        ras_nx_s;
    logic        cas_nx_s;
    logic        wr_nx_s;
    logic        rd_nx_s;

    // Slot arbitration: the slot parity picks which requester has priority
    always_comb begin
        arb_s = GNT_IDLE;
        if (parity_r == 1'b0) begin
            if (i_VID_REQ) begin
                arb_s = GNT_VID;
            end else if (i_CPU_REQ) begin
                arb_s = GNT_CPU;
            end else if (REFRESH_EN) begin
                arb_s = GNT_REF;
            end else begin
                arb_s = GNT_IDLE;
            end
        end else begin
            if (i_CPU_REQ) begin
                arb_s = GNT_CPU;
            end else if (i_VID_REQ) begin
                arb_s = GNT_VID;
            end else if (REFRESH_EN) begin
                arb_s = GNT_REF;
            end else begin
                arb_s = GNT_IDLE;
            end
        end
    end

    // Next slot context: the edge ending p0 latches the winner, later edges hold it
    always_comb begin
        phase_nx_s = phase_r + 3'd1;
        grant_nx_s = grant_r;
        addr_nx_s  = addr_lat_r;
        we_nx_s    = we_lat_r;
        din_nx_s   = din_lat_r;
        if (phase_r == 3'd0) begin
            grant_nx_s = arb_s;
            case (arb_s)
                GNT_VID: begin
                    addr_nx_s = i_VID_ADDR;
                    we_nx_s   = 1'b0;
                    din_nx_s  = 4'h0;
                end
                GNT_CPU: begin
                    addr_nx_s = i_CPU_ADDR;
                    we_nx_s   = i_CPU_WE;
                    din_nx_s  = i_CPU_DIN;
                end
                default: begin
                    addr_nx_s = addr_lat_r;
                    we_nx_s   = 1'b0;
                    din_nx_s  = 4'h0;
                end
            endcase
        end else begin
            grant_nx_s = grant_r;
        end
    end

    // Per-phase strobe and address decode for the phase about to start
    always_comb begin
        row_s          = addr_nx_s[7:0];
        col_s          = {1'b0, addr_nx_s[13:8], 1'b0};
        is_write_s     = (grant_nx_s == GNT_CPU) && we_nx_s;
        dram_addr_nx_s = dram_addr_r;
        dram_din_nx_s  = 4'h0;
        ras_nx_s       = 1'b1;
        cas_nx_s       = 1'b1;
        wr_nx_s        = 1'b1;
        rd_nx_s        = 1'b1;
        case (grant_nx_s)
            GNT_VID, GNT_CPU: begin
                case (phase_nx_s)
                    3'd1: begin
                        dram_addr_nx_s = row_s;
                    end
                    3'd2, 3'd3: begin
                        dram_addr_nx_s = row_s;
                        ras_nx_s       = 1'b0;
                    end
                    3'd4: begin
                        dram_addr_nx_s = col_s;
                        ras_nx_s       = 1'b0;
                        cas_nx_s       = 1'b0;
                    end
                    3'd5, 3'd6: begin
                        dram_addr_nx_s = col_s;
                        ras_nx_s       = 1'b0;
                        cas_nx_s       = 1'b0;
                        wr_nx_s        = ~is_write_s;
                        rd_nx_s        = is_write_s;
                    end
                    3'd7: begin
                        dram_addr_nx_s = col_s;
                    end
                    default: begin
                        dram_addr_nx_s = dram_addr_r;
                    end
                endcase
                if (is_write_s && (phase_nx_s != 3'd0)) begin
                    dram_din_nx_s = din_nx_s;
                end else begin
                    dram_din_nx_s = 4'h0;
                end
            end
            GNT_REF: begin
                if (phase_nx_s != 3'd0) begin
                    dram_addr_nx_s = refcnt_r;
                end else begin
                    dram_addr_nx_s = dram_addr_r;
                end
                if ((phase_nx_s >= 3'd2) && (phase_nx_s <= 3'd6)) begin
                    ras_nx_s = 1'b0;
                end else begin
                    ras_nx_s = 1'b1;
                end
            end
            default: begin
                dram_addr_nx_s = dram_addr_r;
            end
        endcase
    end

    // Phase counter, slot parity, grant latch and refresh row counter
    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            phase_r    <= 3'd0;
            parity_r   <= 1'b0;
            grant_r    <= GNT_IDLE;
            addr_lat_r <= 14'h0000;
            we_lat_r   <= 1'b0;
            din_lat_r  <= 4'h0;
            refcnt_r   <= 8'h00;
        end else begin
            phase_r    <= phase_nx_s;
            grant_r    <= grant_nx_s;
            addr_lat_r <= addr_nx_s;
            we_lat_r   <= we_nx_s;
            din_lat_r  <= din_nx_s;
            if (phase_r == 3'd7) begin
                parity_r <= ~parity_r;
                if (grant_r == GNT_REF) begin
                    refcnt_r <= refcnt_r + 8'd1;
                end
            end
        end
    end

    // DRAM-side output registers
    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            dram_addr_r <= 8'h00;
            dram_din_r  <= 4'h0;
            ras_n_r     <= 1'b1;
            cas_n_r     <= 1'b1;
            wr_n_r      <= 1'b1;
            rd_n_r      <= 1'b1;
        end else begin
            dram_addr_r <= dram_addr_nx_s;
            dram_din_r  <= dram_din_nx_s;
            ras_n_r     <= ras_nx_s;
            cas_n_r     <= cas_nx_s;
            wr_n_r      <= wr_nx_s;
            rd_n_r      <= rd_nx_s;
        end
    end

    // Read-data capture at the end of p6 and one-cycle completion pulse in p7
    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            vid_data_r  <= 4'h0;
            cpu_dout_r  <= 4'h0;
            vid_valid_r <= 1'b0;
            cpu_ack_r   <= 1'b0;
        end else begin
            vid_valid_r <= (phase_r == 3'd6) && (grant_r == GNT_VID);
            cpu_ack_r   <= (phase_r == 3'd6) && (grant_r == GNT_CPU);
            if ((phase_r == 3'd6) && (grant_r == GNT_VID)) begin
                vid_data_r <= i_DRAM_DOUT;
            end
            if ((phase_r == 3'd6) && (grant_r == GNT_CPU) && !we_lat_r) begin
                cpu_dout_r <= i_DRAM_DOUT;
            end
        end
    end

    assign o_DRAM_ADDR = dram_addr_r;
    assign o_DRAM_DIN  = dram_din_r;
    assign o_RAS_n     = ras_n_r;
    assign o_CAS_n     = cas_n_r;
    assign o_WR_n      = wr_n_r;
    assign o_RD_n      = rd_n_r;
    assign o_VID_DATA  = vid_data_r;
    assign o_VID_VALID = vid_valid_r;
    assign o_CPU_DOUT  = cpu_dout_r;
    assign o_CPU_ACK   = cpu_ack_r;

endmodule
